// File: rtl/alu_instr_sequencer.sv
// Control-unit sequencer for the datapath.
// It fetches one instruction (PC -> MAR, memory -> MDR -> IR) and then runs the
// register-register or unary ALU steps. MUL and DIV also get a HI/LO writeback.
// T1 can absorb memory wait states up to a bounded count. The sequencer can
// chain instructions back to back.
module alu_instr_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Read,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [12:0]         alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                mem_err
);

    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_next;

    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [12:0] op_sel;
    logic        is_unary;
    logic        is_muldiv;
    logic        bad_reg;
    logic        instr_ok;
    logic        unused_ir_bits;

    // One-hot ALU select; an all-zero result marks an unsupported opcode.
    function automatic logic [12:0] alu_decode(input logic [4:0] op);
        logic [12:0] sel;
        sel = '0;
        case (op)
            OP_AND:  sel[0]  = 1'b1;
            OP_OR:   sel[1]  = 1'b1;
            OP_ADD:  sel[2]  = 1'b1;
            OP_SUB:  sel[3]  = 1'b1;
            OP_MUL:  sel[4]  = 1'b1;
            OP_DIV:  sel[5]  = 1'b1;
            OP_SHR:  sel[6]  = 1'b1;
            OP_SHRA: sel[7]  = 1'b1;
            OP_SHL:  sel[8]  = 1'b1;
            OP_ROR:  sel[9]  = 1'b1;
            OP_ROL:  sel[10] = 1'b1;
            OP_NEG:  sel[11] = 1'b1;
            OP_NOT:  sel[12] = 1'b1;
            default: sel     = '0;
        endcase
        return sel;
    endfunction

    // Register-file select. It is only used for fields already known to be in range.
    function automatic logic [NUM_REGS-1:0] reg_select(input logic [3:0] idx);
        logic [NUM_REGS-1:0] sel;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = (idx == 4'(i));
        end
        return sel;
    endfunction

    function automatic logic reg_out_of_range(input logic [3:0] idx);
        return ({1'b0, idx} >= 5'(NUM_REGS));
    endfunction

    // The low IR bits carry no information for these instruction formats.
    assign unused_ir_bits = ^ir[14:0];

    // Instruction decode. Ra is unused by MUL/DIV and Rc is unused by the unary ops,
    // so neither field can make those instructions illegal.
    always_comb begin
        opcode    = ir[31:27];
        ra        = ir[26:23];
        rb        = ir[22:19];
        rc        = ir[18:15];
        op_sel    = alu_decode(opcode);
        is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
        is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
        bad_reg   = reg_out_of_range(rb)
                  || (!is_muldiv && reg_out_of_range(ra))
                  || (!is_unary && reg_out_of_range(rc));
        instr_ok  = (|op_sel) && !bad_reg;
    end

    // State and memory wait counter; an active-low reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic and per-step strobe decode.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        PCout         = 1'b0;
        PCin          = 1'b0;
        IncPC         = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        IRin          = 1'b0;
        Read          = 1'b0;
        Yin           = 1'b0;
        Zin           = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        Rout          = '0;
        Rin           = '0;
        alu_op        = '0;
        done          = 1'b0;
        illegal       = 1'b0;
        mem_err       = 1'b0;
        busy          = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                wait_cnt_next = '0;
                if (start) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                PCout         = 1'b1;
                MARin         = 1'b1;
                IncPC         = 1'b1;
                Zin           = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_T1;
            end
            S_T1: begin
                // PC+1 stays in Z, so keeping PCin asserted while waiting is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_next = S_T2;
                end else if (wait_cnt == 8'(TIMEOUT)) begin
                    mem_err    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (!instr_ok) begin
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end else if (is_unary) begin
                    Rout       = reg_select(rb);
                    alu_op     = op_sel;
                    Zin        = 1'b1;
                    state_next = S_T5;
                end else begin
                    Rout       = reg_select(rb);
                    Yin        = 1'b1;
                    state_next = S_T4;
                end
            end
            S_T4: begin
                Rout       = reg_select(rc);
                alu_op     = op_sel;
                Zin        = 1'b1;
                state_next = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    state_next = S_T6;
                end else begin
                    Rin        = reg_select(ra);
                    done       = 1'b1;
                    state_next = continuous ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                done       = 1'b1;
                state_next = continuous ? S_T0 : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Control-unit sequencer that generates the per-step control strobes for the datapath. It fetches one instruction through PC/MAR/MDR/IR and executes register-register and unary ALU instructions, including HI/LO writeback for MUL and DIV. It also supports memory wait states with a timeout and back-to-back continuous execution. It sits between the top level and `datapath`, driving the same strobe set that a hand-written bench drives.

## Interface
- `NUM_REGS`, default 16: general registers; legal 2..16. Register fields stay 4 bits.
- `TIMEOUT`, default 15: maximum wait cycles in T1 before `mem_err`; legal 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin fetch; sampled in IDLE only.
- `continuous`  in  1  sampled on the final execute step; high means go to T0 instead of IDLE.
- `mem_ready`  in  1  memory read data valid this cycle.
- `ir`  in  32  IR register contents; valid from T3 onward.
- `PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Yin, Zin, Zlowout, Zhighout, HIin, LOin`  out  1 each  datapath strobes.
- `Rout`, `Rin`  out  NUM_REGS  one-hot or zero register out/in selects.
- `alu_op`  out  13  one-hot ALU select, bit0..12 = AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
- `busy`  out  1  high in every state except IDLE.
- `done`, `illegal`, `mem_err`  out  1 each  single-cycle status pulses.

## Operation
- IR fields: opcode = `ir[31:27]`, Ra = `ir[26:23]`, Rb = `ir[22:19]`, Rc = `ir[18:15]`.
- Supported opcodes: ADD 3, SUB 4, AND 5, OR 6, ROR 7, ROL 8, SHR 9, SHRA 10, SHL 11, MUL 15, DIV 16, NEG 17, NOT 18. Every other opcode is illegal.
- Any used register field ≥ NUM_REGS is also illegal.
- Outputs are a combinational decode of the registered state and `ir`. Every strobe not listed for a state is 0.
- IDLE: all outputs 0. `start`=1 → T0. `start` is ignored in every state other than IDLE.
- T0: PCout, MARin, IncPC, Zin. → T1; the wait counter is cleared.
- T1: Zlowout, PCin, Read, MDRin.
  - `mem_ready`=1 → T2.
  - Otherwise stay in T1 and increment the counter. Re-asserting PCin is harmless because Z is stable.
  - Counter = TIMEOUT with `mem_ready`=0 → `mem_err` pulse that cycle, then IDLE.
- T2: MDRout, IRin. → T3.
- T3, binary ops: Rout[Rb], Yin. → T4.
- T3, unary ops (NEG, NOT): Rout[Rb], alu_op, Zin. → T5.
- T3, illegal instruction: no strobes, `illegal` pulse, → IDLE.
- T4: Rout[Rc], alu_op, Zin. → T5.
- T5, MUL/DIV: Zlowout, LOin. → T6.
- T5, all other ops: Zlowout, Rin[Ra], `done`.
- T6 (MUL/DIV only): Zhighout, HIin, `done`. Ra is ignored for MUL/DIV.
- After the `done` cycle: `continuous`=1 → T0, otherwise → IDLE.
- `reset`=0 in any state: next state IDLE, wait counter 0. All outputs are 0 from the following cycle, including mid-instruction.

## Timing
- Reset value: state IDLE; every output 0.
- Cycles from the T0 cycle to the `done` cycle inclusive, with `mem_ready` high in T1:
  - binary ops: 6;
  - unary ops: 5;
  - MUL/DIV: 7.
- Each wait cycle in T1 adds 1.
- `start` accepted in IDLE at edge k → T0 outputs during cycle k+1.
- Continuous mode: T0 directly follows the `done` cycle with no idle gap.
- Maximum T1 residency is TIMEOUT+1 cycles. `mem_ready` arriving in the timeout cycle wins: → T2, no `mem_err`.
- `Rout` and `Rin` are never both nonzero in the same cycle.
- At most one `alu_op` bit is set.
- `done`, `illegal` and `mem_err` are mutually exclusive.

## Test plan
- Fetch and AND: reset, `ir`=32'h2A2B8000, pulse `start`, `mem_ready`=1.
  - T3: Rout=16'h0020, Yin.
  - T4: Rout=16'h0080, alu_op=13'h0001, Zin.
  - T5: Rin=16'h0010, `done`.
  - busy high for exactly 6 cycles.
- MUL: `ir`=32'h781B8000.
  - T3 Rout[3]; T4 Rout[7] with alu_op bit4.
  - T5 LOin; T6 HIin with `done`; Rin stays 0 throughout.
- Unary NOT with wait states: `ir`=32'h91300000, `mem_ready` low for 3 T1 cycles.
  - T3: Rout[6], alu_op bit12, Zin.
  - T5: Rin[2], `done`.
  - total 8 cycles from T0.
- Illegal: `ir`=32'h00000000 → `illegal` pulse in T3, no Rout/Yin, IDLE next cycle.
- Repeat the illegal case with NUM_REGS=8 and Rc=9; same required response.
- Timeout: `mem_ready` held 0 → `mem_err` on the 16th T1 cycle (TIMEOUT=15), then IDLE.
- Continuous and reset: `continuous`=1 → T0 immediately after `done`. Drive `reset`=0 during T4 → all outputs 0 and IDLE next cycle. A `start` asserted during T2 has no effect.
